// File: rtl/ssd_capture.sv
// Seven-segment display scraper: recovers the hex value shown on each of four multiplexed digits; optional error counter under SSD_CAPTURE_ERRCNT_EN.
// Latency: a pair presented before edge E0 and held is captured at edge E0+STABLE_CYCLES; upd pulses on that edge.
// Backpressure: none, the inputs are free-running display lines and every qualifying capture is taken immediately.
module ssd_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        upd,
    output logic        err,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [7:0]  stab_cnt;
    logic        single;
    logic [1:0]  idx;
    logic        fresh;
    logic        cap;
    logic        dec_hit;
    logic [3:0]  dec_val;
    logic        blank;

    // The count is cleared on the edge a new pair lands, so zero marks a just-changed pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            stab_cnt <= 8'd0;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            if ({an, seg} != {an_q, seg_q})
                stab_cnt <= 8'd0;
            else if (stab_cnt != 8'hFF)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    assign fresh = (stab_cnt == 8'd0);
    assign blank = (seg_q == 7'h7F);

    always_comb begin
        single = 1'b1;
        idx    = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: single = 1'b0;
        endcase
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'h0;
        case (seg_q)
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
            default:    dec_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (single)
                    state_nxt = SETTLE;
            end
            SETTLE: begin
                if (fresh) begin
                    if (!single)
                        state_nxt = IDLE;
                end else if (stab_cnt == CAP_CNT) begin
                    cap       = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (fresh)
                    state_nxt = single ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A clear on the capture edge wins; the FSM still moves to HOLD so the pair is not retaken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            digits <= 16'h0000;
            valid  <= 4'b0000;
            upd    <= 1'b0;
            err    <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (clr) begin
                valid <= 4'b0000;
                err   <= 1'b0;
            end else if (cap) begin
                if (dec_hit) begin
                    digits[{idx, 2'b00} +: 4] <= dec_val;
                    valid[idx]                <= 1'b1;
                    upd                       <= 1'b1;
                end else if (blank) begin
                    valid[idx] <= 1'b0;
                    upd        <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef SSD_CAPTURE_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            err_cnt <= 8'd0;
        else if (clr)
            err_cnt <= 8'd0;
        else if (cap && !dec_hit && !blank && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ssd_capture.sv
// Self-checking bench for ssd_capture: directed scenarios plus randomized traffic against a windowed history model.
module tb_ssd_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  an  = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic        upd;
    logic        err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_digits = 16'h0;
    logic [3:0]  m_valid  = 4'h0;
    logic        m_upd    = 1'b0;
    logic        m_err    = 1'b0;
    int          m_ec     = 0;
    logic [10:0] hist [$];
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    ssd_capture #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .an      (an),
        .seg     (seg),
        .clr     (clr),
        .digits  (digits),
        .valid   (valid),
        .upd     (upd),
        .err     (err),
        .err_cnt (err_cnt)
    );

    function automatic logic [7:0] exp_ec();
`ifdef SSD_CAPTURE_ERRCNT_EN
        return 8'(m_ec);
`else
        return 8'd0;
`endif
    endfunction

    function automatic int zeros(input logic [3:0] a);
        int z = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) z++;
        return z;
    endfunction

    // Capture rule: the last S registered pairs are identical single-anode pairs and the one before differed.
    task automatic model_update();
        logic [10:0] v;
        logic        cap;
        int          n, idx, val;
        m_upd = 1'b0;
        if (!rst) begin
            m_digits = 16'h0;
            m_valid  = 4'h0;
            m_err    = 1'b0;
            m_ec     = 0;
            hist.push_back(11'h7FF);
        end else begin
            n   = hist.size();
            v   = hist[n-1];
            cap = (zeros(v[10:7]) == 1) && (hist[n-1-S] != v);
            for (int k = 1; k < S; k++) if (hist[n-1-k] != v) cap = 1'b0;
            if (clr) begin
                m_valid = 4'h0;
                m_err   = 1'b0;
                m_ec    = 0;
            end else if (cap) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (!v[7+k]) idx = k;
                val = -1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] == v[6:0]) val = k;
                if (val >= 0) begin
                    m_digits[idx*4 +: 4] = 4'(val);
                    m_valid[idx]         = 1'b1;
                    m_upd                = 1'b1;
                end else if (v[6:0] == 7'h7F) begin
                    m_valid[idx] = 1'b0;
                    m_upd        = 1'b1;
                end else begin
                    m_err = 1'b1;
                    if (m_ec < 255) m_ec++;
                end
            end
            hist.push_back({an, seg});
        end
        while (hist.size() > S + 2) hist.delete(0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0; an = 4'b1111; seg = 7'h7F;
        step(); step();
        total++; if (digits !== 16'h0000) begin bad++; $display("FAIL reset_digits: got %h want 0000", digits); end
        total++; if (valid !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want 0000", valid); end
        total++; if ({upd, err} !== 2'b00) begin bad++; $display("FAIL reset_upd_err: got %b want 00", {upd, err}); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_capture();
        int ups = 0;
        an = 4'b1110; seg = 7'b0010010;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (upd) ups++;
            total++; if ({digits, valid, upd, err, err_cnt} !== {m_digits, m_valid, m_upd, m_err, exp_ec()}) begin
                bad++; $display("FAIL model_capture: got %h want %h", {digits, valid, upd, err, err_cnt}, {m_digits, m_valid, m_upd, m_err, exp_ec()});
            end
            if (k == 4) begin
                total++; if ({upd, valid[0]} !== 2'b00) begin bad++; $display("FAIL capture_early: got %b want 00", {upd, valid[0]}); end
            end
            if (k == 5) begin
                total++; if ({digits[3:0], valid, upd} !== {4'h2, 4'b0001, 1'b1}) begin
                    bad++; $display("FAIL capture_e0p4: got %h/%b/%b want 2/0001/1", digits[3:0], valid, upd);
                end
            end
        end
        total++; if (ups != 1) begin bad++; $display("FAIL capture_pulses: got %0d want 1", ups); end
    endtask

    task automatic test_glitch();
        an = 4'b1110; seg = 7'b1001111;
        for (int k = 1; k <= 3; k++) begin
            step();
            total++; if ({upd, digits[3:0]} !== {1'b0, 4'h2}) begin bad++; $display("FAIL glitch_short: got %b/%h want 0/2", upd, digits[3:0]); end
        end
        seg = 7'b0000110;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++; if ({digits, valid, upd, err, err_cnt} !== {m_digits, m_valid, m_upd, m_err, exp_ec()}) begin
                bad++; $display("FAIL model_glitch: got %h want %h", {digits, valid, upd, err, err_cnt}, {m_digits, m_valid, m_upd, m_err, exp_ec()});
            end
            if (k == 4) begin
                total++; if (digits[3:0] !== 4'h2) begin bad++; $display("FAIL glitch_hold: got %h want 2", digits[3:0]); end
            end
            if (k == 5) begin
                total++; if ({digits[3:0], upd} !== {4'h3, 1'b1}) begin bad++; $display("FAIL glitch_new: got %h/%b want 3/1", digits[3:0], upd); end
            end
        end
    endtask

    task automatic test_error();
        logic [3:0] d1;
        logic       v1;
        logic [7:0] want_ec;
        int ups = 0;
        d1 = digits[7:4]; v1 = valid[1];
`ifdef SSD_CAPTURE_ERRCNT_EN
        want_ec = 8'd1;
`else
        want_ec = 8'd0;
`endif
        an = 4'b1101; seg = 7'b1111110;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (upd) ups++;
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL error_flag: got %b want 1", err); end
        total++; if ({digits[7:4], valid[1]} !== {d1, v1}) begin bad++; $display("FAIL error_keep: got %h/%b want %h/%b", digits[7:4], valid[1], d1, v1); end
        total++; if (ups != 0) begin bad++; $display("FAIL error_upd: got %0d want 0", ups); end
        total++; if (err_cnt !== want_ec) begin bad++; $display("FAIL error_cnt: got %0d want %0d", err_cnt, want_ec); end
    endtask

    task automatic test_multi_anode();
        logic [28:0] snap;
        int ups = 0;
        snap = {digits, valid, err, err_cnt};
        an = 4'b1100; seg = 7'b0000000;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (upd) ups++;
        end
        total++; if ({digits, valid, err, err_cnt} !== snap) begin bad++; $display("FAIL multi_keep: got %h want %h", {digits, valid, err, err_cnt}, snap); end
        total++; if (ups != 0) begin bad++; $display("FAIL multi_upd: got %0d want 0", ups); end
    endtask

    task automatic test_clr_capture();
        int ups = 0;
        an = 4'b0111; seg = 7'b0001000;
        for (int k = 1; k <= 4; k++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if ({valid, err, upd, err_cnt} !== {4'b0000, 1'b0, 1'b0, 8'd0}) begin
            bad++; $display("FAIL clr_capture: got %b/%b/%b/%0d want 0000/0/0/0", valid, err, upd, err_cnt);
        end
        for (int k = 1; k <= 10; k++) begin
            step();
            if (upd) ups++;
        end
        total++; if ({ups, valid} !== {32'd0, 4'b0000}) begin bad++; $display("FAIL clr_recapture: got %0d/%b want 0/0000", ups, valid); end
    endtask

    task automatic test_blank();
        int ups = 0;
        an = 4'b1110; seg = 7'b0100100;
        for (int k = 1; k <= 6; k++) step();
        total++; if ({digits[3:0], valid[0]} !== {4'h5, 1'b1}) begin bad++; $display("FAIL blank_pre: got %h/%b want 5/1", digits[3:0], valid[0]); end
        seg = 7'h7F;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (upd) ups++;
            if (k == 5) begin
                total++; if ({upd, valid[0], digits[3:0], err} !== {1'b1, 1'b0, 4'h5, 1'b0}) begin
                    bad++; $display("FAIL blank_capture: got %b/%b/%h/%b want 1/0/5/0", upd, valid[0], digits[3:0], err);
                end
            end
        end
        total++; if (ups != 1) begin bad++; $display("FAIL blank_pulses: got %0d want 1", ups); end
    endtask

    task automatic test_reset_mid_settle();
        an = 4'b1011; seg = 7'b0001111;
        step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++; if ({digits, valid} !== 20'h0) begin bad++; $display("FAIL rstmid_clear: got %h/%b want 0/0", digits, valid); end
        for (int k = 1; k <= 6; k++) begin
            step();
            total++; if (upd !== (k == 5)) begin bad++; $display("FAIL rstmid_upd_%0d: got %b want %b", k, upd, k == 5); end
        end
        total++; if ({digits[11:8], valid[2]} !== {4'h7, 1'b1}) begin bad++; $display("FAIL rstmid_value: got %h/%b want 7/1", digits[11:8], valid[2]); end
    endtask

    task automatic test_back_to_back();
        int ups = 0;
        for (int d = 0; d < 4; d++) begin
            an = ~(4'b0001 << d); seg = seg_tab[8 + d];
            for (int k = 1; k <= S + 1; k++) begin
                step();
                if (upd) ups++;
            end
        end
        total++; if ({digits, valid} !== {16'hBA98, 4'b1111}) begin bad++; $display("FAIL b2b_value: got %h/%b want ba98/1111", digits, valid); end
        total++; if (ups != 4) begin bad++; $display("FAIL b2b_pulses: got %0d want 4", ups); end
    endtask

    task automatic test_long_hold();
        int ups = 0;
        an = 4'b1101; seg = 7'b1001100;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (upd) ups++;
        end
        total++; if (ups != 1) begin bad++; $display("FAIL long_hold_pulses: got %0d want 1", ups); end
    endtask

    task automatic test_errcnt_sat();
        logic [7:0] want_ec;
`ifdef SSD_CAPTURE_ERRCNT_EN
        want_ec = 8'd255;
`else
        want_ec = 8'd0;
`endif
        an = 4'hF; clr = 1'b1;
        step();
        clr = 1'b0; an = 4'b1110;
        for (int i = 0; i < 260; i++) begin
            seg = (i % 2 == 0) ? 7'b1111110 : 7'b1111101;
            for (int k = 1; k <= S; k++) step();
        end
        step();
        total++; if ({err, err_cnt} !== {1'b1, want_ec}) begin bad++; $display("FAIL errcnt_sat: got %b/%0d want 1/%0d", err, err_cnt, want_ec); end
        total++; if ({digits, valid, upd, err, err_cnt} !== {m_digits, m_valid, m_upd, m_err, exp_ec()}) begin
            bad++; $display("FAIL model_errcnt: got %h want %h", {digits, valid, upd, err, err_cnt}, {m_digits, m_valid, m_upd, m_err, exp_ec()});
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int r;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 7);
                r = $urandom_range(0, 9);
                an = (r < 8) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
                r = $urandom_range(0, 19);
                if (r < 12)      seg = seg_tab[$urandom_range(0, 15)];
                else if (r < 15) seg = 7'h7F;
                else             seg = 7'($urandom);
            end
            hold--;
            clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 199) != 0);
            step();
            total++; if ({digits, valid, upd, err, err_cnt} !== {m_digits, m_valid, m_upd, m_err, exp_ec()}) begin
                bad++; $display("FAIL model_random @%0d: got %h want %h", c, {digits, valid, upd, err, err_cnt}, {m_digits, m_valid, m_upd, m_err, exp_ec()});
            end
        end
        clr = 1'b0; rst = 1'b1;
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int k = 0; k < S + 2; k++) hist.push_back(11'h7FF);
        test_reset();
        test_capture();
        test_glitch();
        test_error();
        test_multi_anode();
        test_clr_capture();
        test_blank();
        test_reset_mid_settle();
        test_back_to_back();
        test_long_hold();
        test_errcnt_sat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_capture.md
SSD_CAPTURE -- requirements
Module: ssd_capture

Interface
REQ-001 SHALL provide parameter: STABLE_CYCLES, 4, consecutive identical samples required before capture (legal 2..255).
REQ-002 SHALL provide port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port: an  input  4  digit enables, active-low, an[i] selects digit i.
REQ-005 SHALL provide port: seg  input  7  segments, active-low, seg[6]=ca ... seg[0]=cg.
REQ-006 SHALL provide port: clr  input  1  one-cycle request to clear valid, err, err_cnt.
REQ-007 SHALL provide port: digits  output  16  captured hex values, digits[4i+3:4i] = digit i.
REQ-008 SHALL provide port: valid  output  4  valid[i]=1 when digits for digit i holds a decoded value.
REQ-009 SHALL provide port: upd  output  1  one-cycle pulse on each successful capture.
REQ-010 SHALL provide port: err  output  1  sticky flag, an unrecognised segment pattern was captured.
REQ-011 SHALL provide port: err_cnt  output  8  count of unrecognised captures (see Configuration).

Function
REQ-012 SHALL register an and seg each cycle into a sample pair; all decisions use the registered pair.
REQ-013 SHALL keep an 8-bit stability count: cleared when the sample pair differs from the previous sample pair, otherwise incremented, saturating at 255.
REQ-014 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-015 IDLE -> SETTLE when the sample pair has exactly one an bit low; stays IDLE for zero or two-plus low bits.
REQ-016 SETTLE -> HOLD when the stability count reaches STABLE_CYCLES-1, performing the capture on that edge; SETTLE -> IDLE if the pair changes to a non-single-anode value; a change to another single-anode value stays SETTLE with count cleared.
REQ-017 HOLD -> SETTLE (single anode) or IDLE (otherwise) on any change of the sample pair; no re-capture while in HOLD.
REQ-018 Latency: pair presented before edge E0 and held constant SHALL update digits/valid/upd at edge E0+STABLE_CYCLES.
REQ-019 Decode table (seg -> value): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->b, 0110001->C, 1000010->d, 0110000->E, 0111000->F.
REQ-020 Capture of a table pattern SHALL write the value to digit i, set valid[i], pulse upd.
REQ-021 Capture of 1111111 (blank) SHALL clear valid[i], keep digit i value, pulse upd, no error.
REQ-022 Capture of any other pattern SHALL leave digit i and valid[i] unchanged, set err, no upd pulse.
REQ-023 clr SHALL clear valid, err, err_cnt on the next edge; a capture on the same edge is discarded (FSM still advances to HOLD).
REQ-024 upd SHALL be high for exactly one cycle per capture.

Reset
REQ-025 rst=0 at an edge SHALL force: digits=0, valid=0, upd=0, err=0, err_cnt=0, stability count=0, sample pair=all ones, FSM=IDLE.
REQ-026 Reset mid-SETTLE SHALL abandon the pending capture; capture requires a fresh STABLE_CYCLES window after rst returns high.

Configuration
REQ-027 Macro SSD_CAPTURE_ERRCNT_EN defined: err_cnt increments on every REQ-022 capture, saturating at 255, cleared by clr/rst.
REQ-028 Macro undefined: err_cnt SHALL be constant 0 and no counter logic SHALL be present; all other behaviour identical.

Verification (STABLE_CYCLES=4)
REQ-029 rst=0 two cycles, an=1111 -> digits=16'h0000, valid=0000, upd=0, err=0, err_cnt=0.
REQ-030 an=1110, seg=0010010 held 10 cycles from E0 -> digits[3:0]=2, valid=0001 at E0+4, single upd pulse.
REQ-031 an=1110, seg=1001111 for 3 cycles then seg=0000110 held -> no capture of 1; digits[3:0]=3 four edges after change.
REQ-032 an=1101, seg=1111110 held -> err=1, digits[7:4] and valid[1] unchanged, no upd; err_cnt=1 with macro, 0 without.
REQ-033 an=1100 held 20 cycles with valid seg -> FSM stays IDLE, no upd, outputs unchanged.
REQ-034 clr asserted on the capture edge of an=0111, seg=0001000 -> valid[3]=0, err=0, no upd; no re-capture until pair changes.
